// File: rtl/nn_pkg.sv
// Shared constants for the 6-7-3 sensor network: weights, biases, widths and the sequencer state type.
package nn_pkg;

   localparam int unsigned HACC_W_DEF = 14;
   localparam int unsigned OACC_W_DEF = 28;
   localparam int unsigned COEF_W     = 16;
   localparam int unsigned H_W        = 12;
   localparam int unsigned O_W        = 26;
   localparam int unsigned N_IN       = 6;
   localparam int unsigned N_HID      = 7;
   localparam int unsigned N_OUT      = 3;

   typedef logic signed [COEF_W-1:0] coef_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HID  = 3'd1,
      OUT  = 3'd2,
      ARG  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam coef_t W_HID [N_HID][N_IN] = '{
      '{-16'sd30,  16'sd12, -16'sd25,  16'sd8,  -16'sd40,  16'sd20},
      '{ 16'sd35, -16'sd10,  16'sd22, -16'sd15,  16'sd18,  16'sd9 },
      '{-16'sd12,  16'sd40,  16'sd15,  16'sd30, -16'sd20, -16'sd8 },
      '{ 16'sd25,  16'sd18, -16'sd30,  16'sd45,  16'sd10, -16'sd22},
      '{-16'sd50, -16'sd20,  16'sd14, -16'sd10,  16'sd33,  16'sd5 },
      '{ 16'sd10,  16'sd28,  16'sd36, -16'sd18, -16'sd12,  16'sd40},
      '{ 16'sd44, -16'sd33,  16'sd5,   16'sd21,  16'sd27, -16'sd16}
   };

   localparam coef_t B_HID [N_HID] = '{
      16'sd89, -16'sd20, -16'sd10, -16'sd5, 16'sd40, -16'sd30, -16'sd1
   };

   localparam coef_t W_OUT [N_OUT][N_HID] = '{
      '{16'sd100, -16'sd40,  16'sd70, -16'sd20, 16'sd50,  16'sd30, -16'sd60},
      '{16'sd900,  16'sd80, -16'sd90,  16'sd60, 16'sd100, -16'sd70, 16'sd20},
      '{16'sd250,  16'sd30,  16'sd40, -16'sd80, 16'sd120, 16'sd90,  16'sd110}
   };

   localparam coef_t B_OUT [N_OUT] = '{
      16'sd1326, 16'sd1339, 16'sd146
   };

endpackage

// File: rtl/nn_mac.sv
// Single shared signed multiply-accumulate unit with synchronous clear and bias load.
module nn_mac
   import nn_pkg::*;
#(
   parameter int unsigned ACC_W = OACC_W_DEF,
   parameter int unsigned CF_W  = COEF_W,
   parameter int unsigned OPD_W = H_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    en,
   input  logic signed [CF_W-1:0]  coef,
   input  logic [OPD_W-1:0]        opd,
   input  logic signed [CF_W-1:0]  bias,
   output logic signed [ACC_W-1:0] acc
);

   localparam int unsigned PROD_W = CF_W + OPD_W + 1;

   logic signed [PROD_W-1:0] prod_c;

   // Operand is an unsigned activation, so it is zero-extended before the signed multiply.
   assign prod_c = PROD_W'(coef) * PROD_W'($signed({1'b0, opd}));

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (load) begin
         acc <= ACC_W'(bias);
      end else if (en) begin
         acc <= acc + ACC_W'(prod_c);
      end
   end

endmodule

// File: rtl/nn_sequencer.sv
// Serial 6-7-3 network inference: one MAC walks hidden then output nodes, then an argmax picks the move.
module nn_sequencer
   import nn_pkg::*;
#(
   parameter int unsigned HACC_W = HACC_W_DEF,
   parameter int unsigned OACC_W = OACC_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] sensors,
   output logic       busy,
   output logic       done,
   output logic [1:0] move,
   output logic       valid
);

   state_t state, state_nx;

   logic [2:0]               node, term;
   logic [2:0]               tidx_c;
   logic [1:0]               oidx_c;
   logic                     last_hid_c, last_out_c;
   logic [5:0]               sens_q;
   logic [H_W-1:0]           h [N_HID];
   logic [O_W-1:0]           o_q [2];

   logic                     accept_c, mac_load_c, mac_en_c;
   logic signed [COEF_W-1:0] coef_c, bias_c;
   logic [H_W-1:0]           opd_c;
   logic signed [OACC_W-1:0] acc;
   logic signed [HACC_W-1:0] hacc_c;
   logic [H_W-1:0]           hrelu_c;
   logic [O_W-1:0]           orelu_c;
   logic [1:0]               move_c;

   assign tidx_c     = (term == 3'd0) ? 3'd0 : term - 3'd1;
   assign oidx_c     = (node > 3'd2) ? 2'd0 : node[1:0];
   assign last_hid_c = (node == 3'd6) && (term == 3'd6);
   assign last_out_c = (node == 3'd2) && (term == 3'd7);

   // ReLU views of the accumulator; a finished node is read on the following node's bias cycle.
   assign hacc_c  = HACC_W'(acc);
   assign hrelu_c = (!hacc_c[HACC_W-1] && (hacc_c != '0)) ? hacc_c[H_W-1:0] : '0;
   assign orelu_c = (!acc[OACC_W-1] && (acc != '0)) ? acc[O_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = HID;
         HID:     if (last_hid_c) state_nx = OUT;
         OUT:     if (last_out_c) state_nx = ARG;
         ARG:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Term 0 of every node loads the bias; the remaining terms accumulate weight*input.
   always_comb begin
      accept_c   = 1'b0;
      mac_load_c = 1'b0;
      mac_en_c   = 1'b0;
      coef_c     = '0;
      bias_c     = '0;
      opd_c      = '0;
      case (state)
         IDLE: accept_c = start;
         HID: begin
            mac_load_c = (term == 3'd0);
            mac_en_c   = (term != 3'd0);
            bias_c     = B_HID[node];
            coef_c     = W_HID[node][tidx_c];
            opd_c      = H_W'(sens_q[tidx_c]);
         end
         OUT: begin
            mac_load_c = (term == 3'd0);
            mac_en_c   = (term != 3'd0);
            bias_c     = B_OUT[oidx_c];
            coef_c     = W_OUT[oidx_c][tidx_c];
            opd_c      = h[tidx_c];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         node <= '0;
         term <= '0;
      end else begin
         case (state)
            HID: begin
               if (term == 3'd6) begin
                  term <= '0;
                  node <= (node == 3'd6) ? '0 : node + 3'd1;
               end else begin
                  term <= term + 3'd1;
               end
            end
            OUT: begin
               if (term == 3'd7) begin
                  term <= '0;
                  node <= (node == 3'd2) ? '0 : node + 3'd1;
               end else begin
                  term <= term + 3'd1;
               end
            end
            default: begin
               node <= '0;
               term <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h   <= '{default: '0};
         o_q <= '{default: '0};
      end else begin
         if (state == HID && term == 3'd0 && node != 3'd0) h[node - 3'd1] <= hrelu_c;
         if (state == OUT && term == 3'd0 && node == 3'd0) h[N_HID-1] <= hrelu_c;
         if (state == OUT && term == 3'd0 && node != 3'd0) o_q[node[1]] <= orelu_c;
      end
   end

   // Strict compares so ties fall to the higher-indexed output; o3 is still in the accumulator.
   always_comb begin
      move_c = 2'd2;
      if (o_q[0] > o_q[1] && o_q[0] > orelu_c) begin
         move_c = 2'd0;
      end else if (o_q[0] <= o_q[1] && o_q[1] > orelu_c) begin
         move_c = 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         move   <= 2'd0;
         valid  <= 1'b0;
         sens_q <= '0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state == ARG);
         if (state == ARG) begin
            move  <= move_c;
            valid <= 1'b1;
         end
         if (accept_c) sens_q <= sensors;
      end
   end

   nn_mac #(
      .ACC_W (OACC_W),
      .CF_W  (COEF_W),
      .OPD_W (H_W)
   ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .load (mac_load_c),
      .en   (mac_en_c),
      .coef (coef_c),
      .opd  (opd_c),
      .bias (bias_c),
      .acc  (acc)
   );

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed bench for nn_sequencer: latency, argmax decision, start/reset handling and input latching.
module tb_nn_sequencer;
   import nn_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] sensors;
   logic       busy;
   logic       done;
   logic [1:0] move;
   logic       valid;

   int cyc;
   int n_cmp;
   int n_err;

   nn_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .sensors (sensors),
      .busy    (busy),
      .done    (done),
      .move    (move),
      .valid   (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference network in plain integer arithmetic.
   function automatic int golden_move(input logic [5:0] s);
      int hv[7];
      int ov[3];
      int a;
      for (int j = 0; j < int'(N_HID); j++) begin
         a = int'(B_HID[j]);
         for (int i = 0; i < int'(N_IN); i++) if (s[i]) a += int'(W_HID[j][i]);
         hv[j] = (a > 0) ? a : 0;
      end
      for (int k = 0; k < int'(N_OUT); k++) begin
         a = int'(B_OUT[k]);
         for (int j = 0; j < int'(N_HID); j++) a += int'(W_OUT[k][j]) * hv[j];
         ov[k] = (a > 0) ? a : 0;
      end
      if (ov[0] > ov[1] && ov[0] > ov[2]) return 0;
      if (ov[0] <= ov[1] && ov[1] > ov[2]) return 1;
      return 2;
   endfunction

   // mode 0: plain, 1: toggle sensors every cycle, 2: extra start pulses at +10/+40
   task automatic run_inf(input logic [5:0] s, input int mode, input int win,
                          output int lat, output int ndone, output int mv, output int vld);
      int n;
      @(negedge clk);
      sensors = s;
      start   = 1'b1;
      n       = cyc;
      lat = -1; ndone = 0; mv = -1; vld = -1;
      for (int k = 1; k <= win; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = cyc - n;
               mv  = int'(move);
               vld = int'(valid);
            end
         end
         start = (mode == 2 && (k == 10 || k == 40)) ? 1'b1 : 1'b0;
         if (mode == 1) sensors = sensors ^ 6'h3f;
      end
      start = 1'b0;
   endtask

   int lat, nd, mv, vld, n, nbl;
   int dn[3];
   int bl[2];

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      start = 1'b1;
      sensors = 6'h00;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_move", int'(move), 0);
      check("rst_valid", int'(valid), 0);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("start_during_rst_ignored", int'(busy), 0);

      // All-zero sensors: hand-computed node values
      run_inf(6'h00, 0, 77, lat, nd, mv, vld);
      check("zero_lat", lat, 75);
      check("zero_move", mv, 1);
      check("zero_valid", vld, 1);
      check("zero_ndone", nd, 1);
      check("zero_h1", int'(dut.h[0]), 89);
      check("zero_h2", int'(dut.h[1]), 0);
      check("zero_h5", int'(dut.h[4]), 40);
      check("zero_h7", int'(dut.h[6]), 0);
      check("zero_o1", int'(dut.o_q[0]), 12226);
      check("zero_o2", int'(dut.o_q[1]), 85439);
      check("zero_o3", int'(dut.u_mac.acc), 27196);
      check("zero_busy_after", int'(busy), 0);
      check("zero_move_held", int'(move), 1);

      for (int v = 0; v < 64; v++) begin
         run_inf(6'(v), 0, 77, lat, nd, mv, vld);
         check($sformatf("lat_v%0d", v), lat, 75);
         check($sformatf("move_v%0d", v), mv, golden_move(6'(v)));
      end

      // Starts while busy are ignored
      run_inf(6'h0f, 2, 90, lat, nd, mv, vld);
      check("busy_start_lat", lat, 75);
      check("busy_start_ndone", nd, 1);
      check("busy_start_move", mv, golden_move(6'h0f));

      // Sensor changes after acceptance do not disturb the inference
      run_inf(6'h2a, 1, 77, lat, nd, mv, vld);
      check("toggle_lat", lat, 75);
      check("toggle_move", mv, golden_move(6'h2a));

      // Mid-inference reset after a run that left move=1, valid=1
      run_inf(6'h00, 0, 77, lat, nd, mv, vld);
      @(negedge clk);
      sensors = 6'h00;
      start = 1'b1;
      n = cyc;
      nd = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 31) begin
            check("midrst_busy", int'(busy), 0);
            check("midrst_valid", int'(valid), 0);
            check("midrst_move", int'(move), 0);
         end
         if (done) nd++;
         rst = (k == 30) ? 1'b1 : 1'b0;
      end
      check("midrst_no_done", nd, 0);
      run_inf(6'h31, 0, 77, lat, nd, mv, vld);
      check("post_rst_lat", lat, 75);
      check("post_rst_move", mv, golden_move(6'h31));
      check("post_rst_valid", vld, 1);

      // Start held high: back-to-back inferences every 76 cycles
      @(negedge clk);
      sensors = 6'h15;
      start = 1'b1;
      n = cyc;
      nd = 0;
      nbl = 0;
      for (int k = 1; k <= 227; k++) begin
         @(negedge clk);
         if (done) begin
            if (nd < 3) dn[nd] = cyc - n;
            nd++;
         end
         if (!busy) begin
            if (nbl < 2) bl[nbl] = cyc - n;
            nbl++;
         end
         if (k == 227) start = 1'b0;
      end
      check("held_ndone", nd, 3);
      check("held_done0", dn[0], 75);
      check("held_done1", dn[1], 151);
      check("held_done2", dn[2], 227);
      check("held_nbusy_low", nbl, 2);
      check("held_idle0", bl[0], 76);
      check("held_idle1", bl[1], 152);
      check("held_move", int'(move), golden_move(6'h15));
      repeat (3) @(negedge clk);
      check("held_release_idle", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
